rf_sequencer: RTL
=================

Name: rf_sequencer

Overview:
Initiator-side controller for the 8x16 register file.
- Accepts 16-bit instructions over a valid/ready handshake.
- Drives the RF read addresses and write port, waits for the RF's one-cycle registered read data, performs the ALU operation and writes the result back.
- Sits between the instruction source (testbench/top FSM) and the register file; one instruction in flight at a time.

Parameters:
DW, 16, data/RF word width
AW, 3, RF address width (8 registers)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_N  input  1  synchronous active-low reset
instr_valid  input  1  instruction offered
instr_ready  output  1  sequencer can accept (high only in IDLE)
instr  input  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6 (LDI)
rf_num_R1  output  AW  RF read address 1
rf_num_R2  output  AW  RF read address 2
rf_W1  output  AW  RF write address
rf_WE  output  1  RF write enable
rf_Din  output  DW  RF write data
rf_Dout_1  input  DW  RF read data 1 (valid cycle after address presented)
rf_Dout_2  input  DW  RF read data 2
done  output  1  one-cycle pulse, instruction retired
result  output  DW  value written (held until next done)
illegal  output  1  one-cycle pulse with done for undefined opcode

Behaviour:
- Reset (RST_N=0 at edge): state=IDLE, instr_ready=1, rf_WE=0, done=0, illegal=0, result=0, latched instr=0. A reset mid-instruction aborts it; no write occurs in the cycle after reset.
- Opcodes:
  - 0 NOP
  - 1 ADD
  - 2 SUB (rs1-rs2)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SLL (rs1 << rs2[3:0])
  - 7 SRL (logical)
  - 8 LDI (rd <= sign-extended imm6)
  - 9 MOV (rd <= rs1)
  - 10-15 illegal
- Arithmetic is modulo 2^DW; carry/borrow is discarded unless the optional feature is compiled in.
- FSM IDLE -> READ -> EXEC -> DONE -> IDLE:
  - IDLE: instr_ready=1. A handshake (instr_valid & instr_ready) latches instr. NOP/illegal go to DONE, LDI goes to EXEC, all others go to READ.
  - READ: rf_num_R1=rs1, rf_num_R2=rs2 driven from the latched instr. The RF registers its outputs at the end of this cycle.
  - EXEC: compute from rf_Dout_1/2 (or imm6 for LDI). rf_WE=1, rf_W1=rd, rf_Din=result for exactly this cycle. Latch result.
  - DONE: done=1 for one cycle; illegal=1 also if the opcode was illegal. result is unchanged for NOP/illegal.
- Latency, handshake cycle = T:
  - ALU ops: write at end of T+2, done at T+3.
  - LDI: write at end of T+1, done at T+2.
  - NOP/illegal: done at T+1.
- Next instruction is accepted no earlier than the cycle after DONE (IDLE). This serialisation guarantees the RF's read-before-write timing never returns stale data.
- rf_WE is 0 in every state except EXEC. Read addresses hold their last value outside READ (don't-care for the RF).
- instr_valid while busy is ignored (not latched). The source must hold instr stable until ready.
- rd=rs1=rs2 (e.g. ADD r3,r3,r3) is legal and reads the old value.

Optional Feature:
RF_SEQ_FLAGS_EN
- Defined: adds outputs flag_z, flag_n, flag_c (1 bit each), updated in EXEC for ALU/LDI/MOV and reset to 0.
  - z = result==0
  - n = result[DW-1]
  - c = carry-out for ADD, borrow for SUB, last bit shifted out for SLL/SRL, 0 otherwise
  - Flags hold for NOP/illegal.
- Undefined: ports absent, no flag logic, carry discarded.

Decomposition:
- Package rf_seq_pkg:
  - opcode enum (OP_NOP..OP_MOV)
  - state enum (S_IDLE, S_READ, S_EXEC, S_DONE)
  - instruction field bit positions
  - DW/AW defaults
- Sub-module rf_seq_alu: purely combinational (op, a, b, imm6 -> result, carry). Keeps the FSM file to control only.

Test Plan:
- Reset then LDI r1,#5; LDI r2,#-3 -> rf_WE pulses with W1=1 Din=0x0005, then W1=2 Din=0xFFFD; done 2 cycles after each handshake.
- ADD r3,r1,r2 -> READ drives R1=1 R2=2; EXEC writes r3=0x0002; done at T+3, result=0x0002.
- SUB r4,r1,r1 -> r4=0x0000; with RF_SEQ_FLAGS_EN, flag_z=1 and flag_c=0. SLL r5,r1,r1 (r1=5) -> r5=0x00A0.
- Opcode 0xC offered -> done and illegal pulse at T+1, no rf_WE; result unchanged. instr_valid held high through busy -> exactly one acceptance per DONE.
- RST_N=0 during EXEC of ADD -> no rf_WE in the following cycle; instr_ready=1 and all outputs at reset values one cycle after reset deasserts.
- Back-to-back ADD r1,r1,r1 four times starting from r1=1 -> r1 = 2, 4, 8, 16; each read sees the prior write.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// rtl/rf_seq_pkg.sv - shared types, field positions and defaults for the rf_sequencer slice
package rf_seq_pkg;

  localparam int DW_DEF  = 16;
  localparam int AW_DEF  = 3;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_LDI = 4'd8,
    OP_MOV = 4'd9
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_DONE
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
  } flags_t;

  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_MOV;
  endfunction

endpackage

// File: rtl/rf_seq_alu.sv
// rtl/rf_seq_alu.sv - combinational ALU for rf_sequencer; RF_SEQ_FLAGS_EN adds the carry output
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  opcode_e       op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [5:0]    imm6_i,
  output logic [DW-1:0] y_o
`ifdef RF_SEQ_FLAGS_EN
  ,
  output logic          carry_o
`endif
);

  logic [3:0] shamt;
  assign shamt = b_i[3:0];

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_SLL:  y_o = a_i << shamt;
      OP_SRL:  y_o = a_i >> shamt;
      OP_LDI:  y_o = {{(DW-6){imm6_i[5]}}, imm6_i};
      OP_MOV:  y_o = a_i;
      default: y_o = '0;
    endcase
  end

`ifdef RF_SEQ_FLAGS_EN
  localparam int SW = $clog2(DW);
  logic [SW-1:0] sll_idx;
  logic [SW-1:0] srl_idx;
  logic [DW-1:0] sum;

  // Index of the last bit to leave the word for a non-zero shift amount.
  assign sll_idx = SW'(DW - int'(shamt));
  assign srl_idx = SW'(int'(shamt) - 1);
  assign sum     = a_i + b_i;

  always_comb begin
    carry_o = 1'b0;
    case (op_i)
      OP_ADD:  carry_o = sum < a_i;
      OP_SUB:  carry_o = a_i < b_i;
      OP_SLL:  carry_o = (shamt != 4'd0) && a_i[sll_idx];
      OP_SRL:  carry_o = (shamt != 4'd0) && a_i[srl_idx];
      default: carry_o = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/rf_sequencer.sv
// rtl/rf_sequencer.sv - single-issue sequencer driving an 8x16 register file; RF_SEQ_FLAGS_EN adds z/n/c flags
module rf_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [AW-1:0] rf_num_R1,
  output logic [AW-1:0] rf_num_R2,
  output logic [AW-1:0] rf_W1,
  output logic          rf_WE,
  output logic [DW-1:0] rf_Din,
  input  logic [DW-1:0] rf_Dout_1,
  input  logic [DW-1:0] rf_Dout_2,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          illegal
`ifdef RF_SEQ_FLAGS_EN
  ,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_c
`endif
);

  state_e        state_q, state_d;
  logic [15:0]   instr_q, instr_d;
  logic [DW-1:0] result_q, result_d;
  logic [DW-1:0] alu_y;
  logic [3:0]    op_in;
  opcode_e       op_q;

  assign op_in = instr[OP_LSB +: 4];
  assign op_q  = opcode_e'(instr_q[OP_LSB +: 4]);

`ifdef RF_SEQ_FLAGS_EN
  flags_t flags_q, flags_d;
  logic   alu_c;
`endif

  rf_seq_alu #(.DW(DW)) u_alu (
    .op_i   (op_q),
    .a_i    (rf_Dout_1),
    .b_i    (rf_Dout_2),
    .imm6_i (instr_q[IMM_LSB +: 6]),
    .y_o    (alu_y)
`ifdef RF_SEQ_FLAGS_EN
    ,
    .carry_o(alu_c)
`endif
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      result_q <= '0;
`ifdef RF_SEQ_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
`ifdef RF_SEQ_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    result_d = result_q;
`ifdef RF_SEQ_FLAGS_EN
    flags_d  = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          // NOP and illegal opcodes retire without touching the RF.
          if (op_illegal(op_in) || op_in == OP_NOP) state_d = S_DONE;
          else if (op_in == OP_LDI)                 state_d = S_EXEC;
          else                                      state_d = S_READ;
        end
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
        result_d = alu_y;
`ifdef RF_SEQ_FLAGS_EN
        flags_d.z = (alu_y == '0);
        flags_d.n = alu_y[DW-1];
        flags_d.c = alu_c;
`endif
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read addresses come straight from the latched instruction, so they hold outside READ.
  assign rf_num_R1   = instr_q[RS1_LSB +: AW];
  assign rf_num_R2   = instr_q[RS2_LSB +: AW];
  assign rf_W1       = instr_q[RD_LSB +: AW];
  assign rf_Din      = alu_y;
  assign rf_WE       = (state_q == S_EXEC);
  assign instr_ready = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE);
  assign illegal     = done && op_illegal(instr_q[OP_LSB +: 4]);
  assign result      = result_q;

`ifdef RF_SEQ_FLAGS_EN
  assign flag_z = flags_q.z;
  assign flag_n = flags_q.n;
  assign flag_c = flags_q.c;
`endif

endmodule
